// File: rtl/hex_pkg.sv
// Shared seven-segment definitions for hex_display_ctrl: segment bit order,
// on-polarity glyphs for the 16 hex codes, and the polarity helper.
package hex_pkg;

    // Bit positions within a 7-bit segment field (bit 6 = g ... bit 0 = a).
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F_BIT = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_A_GLYPH = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B_GLYPH = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_C_GLYPH = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D_GLYPH = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_E_GLYPH = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_F_GLYPH = 7'b1110001;

    localparam logic [SEG_W-1:0] SEG_OFF_ON_POLARITY = 7'b0000000;

    // Convert an on-polarity pattern to the pin polarity of the board.
    function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] on_pattern,
                                                        input bit active_low);
        return active_low ? ~on_pattern : on_pattern;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to on-polarity seven-segment decoder (gfedcba).
module seg7_decode
    import hex_pkg::*;
(
    input  logic [3:0]       digit,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_OFF_ON_POLARITY;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A_GLYPH;
            4'hB: seg = SEG_B_GLYPH;
            4'hC: seg = SEG_C_GLYPH;
            4'hD: seg = SEG_D_GLYPH;
            4'hE: seg = SEG_E_GLYPH;
            4'hF: seg = SEG_F_GLYPH;
            default: seg = SEG_OFF_ON_POLARITY;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller with leading-zero blanking and polarity select.
// Per-digit blinking is built only when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int HEX_W = SEG_W * NUM_DIGITS;
    localparam logic [HEX_W-1:0] HEX_OFF = ACTIVE_LOW ? {HEX_W{1'b1}} : {HEX_W{1'b0}};

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic                    lz_reg;
    logic [HEX_W-1:0]        hex_reg;
    logic [HEX_W-1:0]        hex_next;
    logic [NUM_DIGITS-1:0]   blink_blank;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS:1]     zero_above;
    logic [SEG_W-1:0]        seg_on [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg <= '0;
            lz_reg    <= 1'b0;
            hex_reg   <= HEX_OFF;
        end else begin
            if (load) begin
                value_reg <= value;
                lz_reg    <= blank_lz;
            end
            hex_reg <= hex_next;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]      cnt_reg;
    logic                  phase_reg;
    logic [NUM_DIGITS-1:0] mask_reg;

    // The blink timebase free-runs; load never disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            mask_reg  <= '0;
        end else begin
            if (cnt_reg == CNT_MAX) begin
                cnt_reg   <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load) begin
                mask_reg <= blink_mask;
            end
        end
    end

    assign blink_blank = phase_reg ? mask_reg : '0;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, (BLINK_DIV < 1)};
    assign blink_blank  = '0;
`endif

    assign zero_above[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        seg7_decode u_dec (
            .digit (value_reg[4*gi +: 4]),
            .seg   (seg_on[gi])
        );

        // Digit 0 is exempt from leading-zero blanking so a zero value still shows "0".
        if (gi == 0) begin : g_lsd
            assign digit_blank[gi] = blink_blank[gi];
        end else begin : g_upper
            assign zero_above[gi]  = (value_reg[4*gi +: 4] == 4'h0) && zero_above[gi+1];
            assign digit_blank[gi] = (lz_reg && zero_above[gi]) || blink_blank[gi];
        end

        assign hex_next[SEG_W*gi +: SEG_W] =
            apply_polarity(digit_blank[gi] ? SEG_OFF_ON_POLARITY : seg_on[gi], ACTIVE_LOW);
    end

    assign hex = hex_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: 4 digits, BLINK_DIV=4, both polarities side by side.
module tb_hex_display_ctrl;

`ifdef HEX_DISPLAY_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [27:0] hex_al;
    logic [27:0] hex_ah;

    int checks = 0;
    int errors = 0;

    // Active-low glyphs, hand-inverted from the on-polarity decode table.
    logic [6:0] seg_al [16];

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1'b1)
    ) dut_al (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .hex        (hex_al)
    );

    hex_display_ctrl #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1'b0)
    ) dut_ah (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .hex        (hex_ah)
    );

    task automatic chk(input string tag, input logic [27:0] exp);
        checks++;
        assert (hex_al === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, hex_al, exp);
        end
        checks++;
        assert (hex_ah === ~exp) else begin
            errors++;
            $error("FAIL %s_pol: observed %h expected %h", tag, hex_ah, ~exp);
        end
        $display("check %s: hex=%h", tag, hex_al);
    endtask

    // Capture at the next edge, then wait one more edge for the registered output.
    task automatic load_val(input logic [15:0] v, input bit lz, input logic [3:0] m);
        value = v;
        blank_lz = lz;
        blink_mask = m;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    // Reset, load 1234 with digit 0 blinking, then track the blink from edge 2 to last_n.
    // A load of 5678 is captured at edge 11, mid-period, and must not move the phase.
    task automatic blink_run(input int last_n, input string tag);
        logic [15:0] v;
        logic [6:0]  d0;
        bit          ph;
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_rst"}, 28'hFFFFFFF);
        rst = 1'b0;
        value = 16'h1234;
        blank_lz = 1'b0;
        blink_mask = 4'b0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 2; n <= last_n; n++) begin
            @(negedge clk);
            v  = (n >= 12) ? 16'h5678 : 16'h1234;
            ph = (((n - 1) / 4) % 2) == 1;
            d0 = (BLINK_BUILT && ph) ? 7'b1111111 : seg_al[v[3:0]];
            chk($sformatf("%s_n%0d", tag, n),
                {seg_al[v[15:12]], seg_al[v[11:8]], seg_al[v[7:4]], d0});
            if (n == 10) begin
                value = 16'h5678;
                load = 1'b1;
            end
            if (n == 11) load = 1'b0;
        end
    endtask

    initial begin
        seg_al[0]  = 7'b1000000; seg_al[1]  = 7'b1111001;
        seg_al[2]  = 7'b0100100; seg_al[3]  = 7'b0110000;
        seg_al[4]  = 7'b0011001; seg_al[5]  = 7'b0010010;
        seg_al[6]  = 7'b0000010; seg_al[7]  = 7'b1111000;
        seg_al[8]  = 7'b0000000; seg_al[9]  = 7'b0010000;
        seg_al[10] = 7'b0001000; seg_al[11] = 7'b0000011;
        seg_al[12] = 7'b1000110; seg_al[13] = 7'b0100001;
        seg_al[14] = 7'b0000110; seg_al[15] = 7'b0001110;

        // Reset held for three cycles, then the first edge shows "0000".
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_%0d", i), 28'hFFFFFFF);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

        // Full decode example.
        load_val(16'h12AF, 1'b0, 4'b0000);
        chk("dec_12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

        // All 16 codes on digit 0.
        for (int k = 0; k < 16; k++) begin
            load_val({12'h12A, 4'(k)}, 1'b0, 4'b0000);
            chk($sformatf("sweep_%0h", k),
                {7'b1111001, 7'b0100100, 7'b0001000, seg_al[k]});
        end

        // Leading-zero blanking.
        load_val(16'h00A0, 1'b1, 4'b0000);
        chk("lz_00A0", {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000});
        load_val(16'h0000, 1'b1, 4'b0000);
        chk("lz_0000", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
        load_val(16'h0100, 1'b1, 4'b0000);
        chk("lz_0100", {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});
        load_val(16'h0000, 1'b0, 4'b0000);
        chk("nolz_0000", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

        // Load held high re-captures every cycle.
        blank_lz = 1'b0;
        value = 16'h0001;
        load = 1'b1;
        @(negedge clk);
        value = 16'h0002;
        @(negedge clk);
        chk("hold_1", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001});
        value = 16'h0003;
        @(negedge clk);
        chk("hold_2", {7'b1000000, 7'b1000000, 7'b1000000, 7'b0100100});
        load = 1'b0;
        @(negedge clk);
        chk("hold_3", {7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000});

        // Reset coinciding with a load discards the load.
        rst = 1'b1;
        value = 16'hFFFF;
        load = 1'b1;
        @(negedge clk);
        chk("rst_load", 28'hFFFFFFF);
        rst = 1'b0;
        load = 1'b0;
        @(negedge clk);
        chk("rst_load_after", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

        // Blink: first run stops mid blank half-period, second run resets there.
        blink_run(6, "blinkA");
        blink_run(24, "blinkB");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit seven-segment display controller, successor to the single-digit hex decoder. It latches a NUM_DIGITS-nibble value on a load strobe and drives one registered 7-segment field per digit. It adds optional leading-zero blanking, per-digit blinking and selectable segment polarity. It sits between board-level logic (counters, ALU results, switch readers) and the HEX pins.

## Interface
- NUM_DIGITS, 6: number of displays, 1..8.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period, at least 1.
- ACTIVE_LOW, 1: 1 drives segment-on as 0 (DE-board HEX); 0 drives segment-on as 1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value, blank_lz and blink_mask.
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost.
- blank_lz  in  1  leading-zero blanking request.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks.
- hex  out  7*NUM_DIGITS  segments; digit i = hex[7i+6:7i], bit order g..a (bit 6 = g).

## Operation
- On a load edge, value_r, lz_r and mask_r capture the inputs. With no load, they hold.
- Decode per digit, in on-polarity gfedcba:
  - 0-9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
  - A-F: 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
  - All 16 codes are defined.
- Leading-zero blanking, when lz_r=1:
  - Digit i is blanked if every digit j >= i is 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Blink:
  - A counter counts 0..BLINK_DIV-1 and toggles phase on wrap.
  - While phase=1, digits with mask_r[i]=1 are blanked.
  - load does not reset the counter or phase.
- Blanked digit = all segments off (7'b1111111 when ACTIVE_LOW=1, 7'b0000000 otherwise).
- Polarity: the on-polarity pattern is inverted when ACTIVE_LOW=1.

## Timing
- Reset values:
  - value_r = 0, lz_r = 0, mask_r = 0.
  - counter = 0, phase = 0.
  - hex = all segments off.
- hex is registered. A load sampled at edge k updates the registers at edge k; hex reflects the new value at edge k+1, so latency is 1 cycle from capture.
- After rst deasserts, the first edge drives all digits to "0", because lz_r = 0 after reset.
- Blink timing:
  - phase toggles on the edge where the counter wraps; the blink period is 2*BLINK_DIV cycles.
  - With BLINK_DIV = 1, phase toggles every cycle.
- A load on the same edge as a phase toggle applies both; hex on the next edge uses the new value and the new phase.
- rst mid-blink or mid-load: reset wins; all state returns to reset values and the load is discarded.
- load held high for several cycles: the registers re-capture every cycle.

## Configuration
- HEX_DISPLAY_BLINK_EN defined:
  - The blink counter, phase register and mask_r exist.
  - Blinking works as described above.
- HEX_DISPLAY_BLINK_EN undefined:
  - The blink_mask port remains but is ignored.
  - No counter or phase register is built; phase is constant 0 and no digit ever blinks.
  - All other behaviour is identical.

## Structure
- Package hex_pkg holds:
  - the 16 on-polarity segment constants,
  - SEG_OFF_ON_POLARITY = 7'b0000000,
  - the segment bit-order definition.
- One sub-module, seg7_decode: combinational, 4-bit in and 7-bit on-polarity out, instantiated NUM_DIGITS times via generate.
- Blanking, polarity and output registers stay in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1 unless stated.
- Reset: hold rst for 3 cycles -> hex = 28'hFFFFFFF. One edge after release -> every digit = 7'b1000000.
- Full decode: load value=16'h12AF, blank_lz=0 -> after 1 edge:
  - digit3 = 1111001, digit2 = 0100100, digit1 = 0001000, digit0 = 0001110.
  - Sweep all 16 codes on digit 0 and check each against the decode table.
- Leading-zero blanking:
  - load 16'h00A0, blank_lz=1 -> digits 3 and 2 = 1111111, digit1 = 0001000, digit0 = 1000000.
  - load 16'h0000, blank_lz=1 -> only digit0 = 1000000.
- Blink: load 16'h1234, blink_mask=4'b0001 -> digit0 alternates 4 cycles 0011001 / 4 cycles 1111111; other digits are steady.
  - A load mid-period does not shift the phase boundary.
  - rst mid-period restarts with phase 0.
- Polarity and macro:
  - ACTIVE_LOW=0 -> every output is the bitwise inverse of the ACTIVE_LOW=1 run.
  - HEX_DISPLAY_BLINK_EN undefined with blink_mask=4'b1111 -> no digit ever blanks.
